// File: rtl/led_pulse_stretcher.sv
// LED pulse stretcher: turns one-cycle event strobes into visible flashes.
// Events that arrive mid-flash are queued (saturating) and replayed in turn.
module led_pulse_stretcher #(
  parameter int CLK_PERIOD_NS = 10,
  parameter int ON_TIME_MS    = 50,
  parameter int OFF_TIME_MS   = 50,
  parameter int MAX_PENDING   = 7,
  localparam int ON_CYCLES  = ON_TIME_MS * 1_000_000 / CLK_PERIOD_NS,
  localparam int OFF_CYCLES = OFF_TIME_MS * 1_000_000 / CLK_PERIOD_NS,
  localparam int MAX_CYC    = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES,
  localparam int TW         = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1),
  localparam int PW         = (MAX_PENDING < 1) ? 1 : $clog2(MAX_PENDING + 1)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          event_in,
  output logic          led_out,
  output logic          busy_out,
  output logic [PW-1:0] pending_out,
  output logic          overflow_out
);

  if (ON_CYCLES < 1 || OFF_CYCLES < 1 || MAX_PENDING < 1) begin : g_bad_params
    $error("led_pulse_stretcher: ON/OFF cycles and MAX_PENDING must be >= 1");
  end

  localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CYCLES - 1);
  localparam logic [PW-1:0] P_MAX    = PW'(MAX_PENDING);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_OFF
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          q_full;

  assign q_full = (pending_out == P_MAX);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= S_IDLE;
      timer        <= '0;
      led_out      <= 1'b0;
      busy_out     <= 1'b0;
      pending_out  <= '0;
      overflow_out <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          timer <= '0;
          if (event_in) begin
            state    <= S_ON;
            led_out  <= 1'b1;
            busy_out <= 1'b1;
          end
        end
        S_ON: begin
          if (event_in) begin
            if (!q_full) pending_out <= pending_out + PW'(1);
            else         overflow_out <= 1'b1;
          end
          if (timer == ON_LAST) begin
            state   <= S_OFF;
            timer   <= '0;
            led_out <= 1'b0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_OFF: begin
          if (timer == OFF_LAST) begin
            timer <= '0;
            // an event on this edge cancels the dequeue (+1 -1)
            if (pending_out != '0) begin
              state   <= S_ON;
              led_out <= 1'b1;
              if (!event_in) pending_out <= pending_out - PW'(1);
            end else if (event_in) begin
              state   <= S_ON;
              led_out <= 1'b1;
            end else begin
              state    <= S_IDLE;
              busy_out <= 1'b0;
            end
          end else begin
            timer <= timer + TW'(1);
            if (event_in) begin
              if (!q_full) pending_out <= pending_out + PW'(1);
              else         overflow_out <= 1'b1;
            end
          end
        end
        default: begin
          state    <= S_IDLE;
          timer    <= '0;
          led_out  <= 1'b0;
          busy_out <= 1'b0;
        end
      endcase
    end
  end

endmodule
